// File: rtl/lsu_multicycle_if.sv
// rtl/lsu_multicycle_if.sv - EXU request, memory bus and WBU result bundle for lsu_multicycle
// The master modport is the LSU's view; slave is the EXU/memory/WBU environment.
interface lsu_multicycle_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic              in_we;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [1:0]        out_cause;

  modport master (
    input  in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_data, out_err, out_cause,
    input  out_ready
  );

  modport slave (
    output in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_data, out_err, out_cause,
    output out_ready
  );
endinterface

// File: rtl/lsu_multicycle.sv
// rtl/lsu_multicycle.sv - multi-cycle load/store unit between EXU and WBU
// One operation in flight; misaligned/illegal-size ops fault without touching the bus.
module lsu_multicycle #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  lsu_multicycle_if.master bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_we;
  logic              op_uns;
  logic [1:0]        op_size;
  logic [OFF_W-1:0]  op_off;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [NB-1:0]     mem_wstrb_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_err_q;
  logic [1:0]        out_cause_q;

  logic [OFF_W-1:0]  in_off;
  logic              bad_size;
  logic              misaligned;
  logic [7:0]        size_mask;
  logic [NB-1:0]     in_strb;
  logic [DATA_W-1:0] in_wdata_sh;

  assign in_off = bus.in_addr[OFF_W-1:0];

  always_comb begin
    bad_size = (bus.in_size == 2'd3) && (DATA_W == 32);
    case (bus.in_size)
      2'd0:    begin misaligned = 1'b0;              size_mask = 8'h01; end
      2'd1:    begin misaligned = bus.in_addr[0];    size_mask = 8'h03; end
      2'd2:    begin misaligned = |bus.in_addr[1:0]; size_mask = 8'h0F; end
      default: begin misaligned = |bus.in_addr[2:0]; size_mask = 8'hFF; end
    endcase
    in_strb     = NB'(size_mask) << in_off;
    in_wdata_sh = bus.in_wdata << {in_off, 3'b000};
  end

  // Load data: move the addressed lane to bit 0, keep the access width, then extend.
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] rd_mask;
  logic              rd_sign;
  logic [DATA_W-1:0] load_val;

  always_comb begin
    rd_sh = bus.mem_rdata >> {op_off, 3'b000};
    case (op_size)
      2'd0:    begin rd_mask = DATA_W'(8'hFF);         rd_sign = rd_sh[7];        end
      2'd1:    begin rd_mask = DATA_W'(16'hFFFF);      rd_sign = rd_sh[15];       end
      2'd2:    begin rd_mask = DATA_W'(32'hFFFF_FFFF); rd_sign = rd_sh[31];       end
      default: begin rd_mask = '1;                     rd_sign = rd_sh[DATA_W-1]; end
    endcase
    load_val = (rd_sh & rd_mask) | ((!op_uns && rd_sign) ? ~rd_mask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_we       <= 1'b0;
      op_uns      <= 1'b0;
      op_size     <= 2'd0;
      op_off      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_cause_q <= 2'd0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_we   <= bus.in_we;
          op_uns  <= bus.in_unsigned;
          op_size <= bus.in_size;
          op_off  <= in_off;
          cnt     <= '0;
          if (bad_size || misaligned) begin
            state       <= RESP;
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_cause_q <= bad_size ? 2'd3 : 2'd1;
          end else begin
            state       <= REQ;
            mem_we_q    <= bus.in_we;
            mem_addr_q  <= {bus.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_q <= in_wdata_sh;
            mem_wstrb_q <= in_strb;
          end
        end
        REQ: if (bus.mem_gnt) state <= WAIT;
        WAIT: begin
          // A response arriving on the final counted cycle still wins over the timeout.
          if (bus.mem_rvalid) begin
            state       <= RESP;
            out_data_q  <= op_we ? '0 : load_val;
            out_err_q   <= 1'b0;
            out_cause_q <= 2'd0;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            state       <= RESP;
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_cause_q <= 2'd2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.mem_req   = (state == REQ);
  assign bus.out_valid = (state == RESP);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_cause = out_cause_q;
endmodule

// File: tb/tb_lsu_multicycle.sv
// tb/tb_lsu_multicycle.sv - scoreboard bench for lsu_multicycle (DATA_W = 32, TIMEOUT = 4)
module tb_lsu_multicycle;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_multicycle_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_multicycle #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [1:0]  cause;
  } resp_t;

  resp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || ((int'(addr[2:0]) % (1 << size)) != 0);
  endfunction

  // Reference result built byte by byte from the raw bus word.
  function automatic resp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] rdata, input bit tmo);
    resp_t r;
    int n, off;
    r = '0;
    n = 1 << size;
    off = int'(addr[1:0]);
    if (size == 2'd3) begin
      r.err = 1'b1; r.cause = 2'd3;
    end else if (is_fault(size, addr)) begin
      r.err = 1'b1; r.cause = 2'd1;
    end else if (tmo) begin
      r.err = 1'b1; r.cause = 2'd2;
    end else if (!we) begin
      for (int i = 0; i < n; i++) r.data[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!uns && r.data[8*n-1])
        for (int i = n; i < 4; i++) r.data[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  // rv_dly < 0 withholds mem_rvalid so the op times out.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly, input int rdy_dly);
    resp_t e;
    int k;
    logic [3:0]  strb;
    logic [31:0] exp_wd;
    sb.push_back(model(we, size, uns, addr, rdata, rv_dly < 0));
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_we = we; bus.in_size = size;
    bus.in_unsigned = uns; bus.in_addr = addr; bus.in_wdata = wdata;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (is_fault(size, addr)) begin
      check("fault_no_req", bus.mem_req, 0);
      check("fault_lat", bus.out_valid, 1);
    end else begin
      strb   = 4'(((1 << (1 << size)) - 1) << addr[1:0]);
      exp_wd = wdata << (8 * addr[1:0]);
      check("mem_req", bus.mem_req, 1);
      check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
      check("mem_we", bus.mem_we, we);
      check("mem_wstrb", bus.mem_wstrb, strb);
      if (we) check("mem_wdata", bus.mem_wdata, exp_wd);
      for (k = 0; k < gnt_dly; k++) begin
        @(negedge clk);
        check("req_hold", bus.mem_req, 1);
      end
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      check("wait_no_req", bus.mem_req, 0);
      if (rv_dly >= 0) begin
        repeat (rv_dly) @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
        check("resp_lat", bus.out_valid, 1);
      end else begin
        k = 0;
        while (!bus.out_valid && k < 4 * TIMEOUT + 8) begin
          @(negedge clk);
          k++;
        end
        check("timeout_lat", k, TIMEOUT + 1);
      end
    end
    for (k = 0; k < rdy_dly; k++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, sb[0].data);
      check("hold_cause", {bus.out_err, bus.out_cause}, {sb[0].err, sb[0].cause});
      @(negedge clk);
    end
    e = sb.pop_front();
    check("out_valid", bus.out_valid, 1);
    check("in_ready_resp", bus.in_ready, 0);
    check("out_data", bus.out_data, e.data);
    check("out_err", bus.out_err, e.err);
    check("out_cause", bus.out_cause, e.cause);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("back_idle", bus.in_ready, 1);
    check("valid_drop", bus.out_valid, 0);
  endtask

  // Accept a legal load, optionally grant it, then hit reset mid-flight.
  task automatic reset_mid_op(input bit in_wait);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_we = 1'b0; bus.in_size = 2'd2; bus.in_addr = 32'h8000_0010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (in_wait) begin
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_req", bus.mem_req, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_idle", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid", bus.out_valid, 0);
    check("late_idle", bus.in_ready, 1);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    bus.in_valid = 1'b0; bus.in_we = 1'b0; bus.in_size = 2'd0; bus.in_unsigned = 1'b0;
    bus.in_addr = '0; bus.in_wdata = '0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wstrb", bus.mem_wstrb, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_out_cause", bus.out_cause, 0);
    rst = 1'b0;

    run_op(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1, 0, 0);
    run_op(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 1, 0);
    run_op(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234, 32'h5555_AAAA, 0, 1, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'h0, 0, -1, 0);

    bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    @(negedge clk);
    check("stray_rvalid_valid", bus.out_valid, 0);
    check("stray_rvalid_req", bus.mem_req, 0);

    run_op(1'b0, 2'd1, 1'b1, 32'h8000_000A, 32'h0, 32'h8001_ABCD, 2, 3, 6);
    run_op(1'b0, 2'd1, 1'b0, 32'h8000_000A, 32'h0, 32'h8001_ABCD, 0, 2, 0);

    reset_mid_op(1'b1);
    run_op(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 32'h1357_9BDF, 0, 0, 0);
    reset_mid_op(1'b0);
    run_op(1'b1, 2'd0, 1'b0, 32'h8000_0021, 32'hA5, 32'h0, 1, 0, 1);

    for (int i = 0; i < 20; i++) begin
      rs = 2'($urandom_range(0, 2));
      ra = $urandom;
      run_op(1'($urandom), rs, 1'($urandom), ra, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_multicycle.md
# lsu_multicycle

Parametrised multi-cycle load/store unit that replaces the single-cycle, combinational memory access path between the execute and write-back stages. It accepts one memory operation at a time from the EXU over a valid/ready handshake. It performs the access over a request/grant/response memory port with arbitrary latency, and returns aligned, size-adjusted and sign/zero-extended load data to the WBU over a second valid/ready handshake. It also detects misaligned accesses and bus timeouts, and reports them as access faults instead of touching memory.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, bus data width; legal values 32 or 64; NB = DATA_W/8 byte lanes.
- TIMEOUT, 255, maximum cycles spent waiting for mem_rvalid before a fault; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EXU presents an operation.
- in_ready  out  1  high exactly when the FSM is in IDLE.
- in_we  in  1  1 = store, 0 = load.
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_W = 64).
- in_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  DATA_W  store data, right-justified.
- mem_req  out  1  bus request; held until granted.
- mem_gnt  in  1  bus grant.
- mem_we  out  1  store request.
- mem_addr  out  ADDR_W  in_addr with the low log2(NB) bits cleared.
- mem_wdata  out  DATA_W  store data shifted to its byte lane.
- mem_wstrb  out  NB  byte-enable mask shifted to its lane.
- mem_rvalid  in  1  response or ack (used for both loads and stores).
- mem_rdata  in  DATA_W  raw bus read data.
- out_valid  out  1  result available to the WBU.
- out_ready  in  1  WBU accepts the result.
- out_data  out  DATA_W  extended load data; 0 for stores and faults.
- out_err  out  1  access fault.
- out_cause  out  2  0 = none, 1 = misaligned, 2 = timeout, 3 = illegal size.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE: on in_valid, capture the operation into internal registers and check it:
  - size 3 with DATA_W = 32 → RESP with cause 3.
  - addr not aligned to 2^size bytes → RESP with cause 1.
  - otherwise → REQ.
- REQ: mem_req = 1 and bus outputs are driven from the captured registers; outputs stay stable until mem_gnt. mem_gnt → WAIT.
- WAIT: count cycles from 0.
  - mem_rvalid → RESP. For a load, register rdata >> (8·offset), truncate it to the access size, and extend it.
  - count reaching TIMEOUT without mem_rvalid → RESP with cause 2.
- RESP: out_valid = 1, with out_data/out_err/out_cause held stable until out_ready. out_ready → IDLE.
- offset = addr[log2(NB)-1:0]. Strobe = ((1<<2^size)-1) << offset. Store data is shifted left by 8·offset.
- mem_rvalid or mem_gnt outside the expected state is ignored.
- An operation that faults never raises mem_req.

## Timing
- All outputs except in_ready are registered or decoded from the state. in_ready = (state == IDLE).
- Reset values:
  - out_valid, mem_req, mem_we, out_err = 0.
  - mem_addr, mem_wdata, mem_wstrb, out_data, out_cause = 0.
  - in_ready = 1.
- Best-case latency with mem_gnt in the REQ cycle and mem_rvalid in the first WAIT cycle:
  - accept at cycle 0.
  - mem_req high at cycle 1.
  - WAIT at cycle 2.
  - out_valid high at cycle 3.
- Fault latency: out_valid high 1 cycle after acceptance.
- Timeout: out_valid rises TIMEOUT+1 cycles after entering WAIT.
- No new operation is accepted in the cycle in which out_ready is sampled; the next accept occurs one cycle later, in IDLE.
- Reset asserted mid-operation:
  - immediately forces IDLE and drops mem_req/out_valid.
  - a late mem_rvalid that arrives after reset is ignored.

## Test plan
- Load word, DATA_W = 32, addr 0x80000004, gnt immediate, rvalid after 1 cycle, rdata 0xDEADBEEF → out_valid at cycle 3, out_data 0xDEADBEEF, out_err 0.
- Signed byte load at addr 0x80000003, rdata 0x80FF0000, for both extension settings:
  - in_unsigned 0 → mem_addr 0x80000000, out_data 0xFFFFFF80.
  - in_unsigned 1 → out_data 0x00000080.
- Store half at addr 0x80000002, wdata 0x1234 → mem_wstrb 0b1100, mem_wdata 0x12340000, mem_we 1; rvalid ack gives out_data 0.
- Misaligned word load at addr 0x80000002 → mem_req never rises, out_valid 1 cycle later, out_err 1, out_cause 1. Separately, size 3 with DATA_W = 32 → out_cause 3.
- TIMEOUT = 4, mem_gnt given, mem_rvalid withheld → out_err 1 and out_cause 2 after 5 WAIT cycles. A rvalid pulse afterwards in IDLE has no effect.
- out_ready held low for 6 cycles in RESP → outputs stable. Also assert rst during WAIT → mem_req and out_valid go to 0 immediately, and the next operation completes normally.
